alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 30 +++
 rtl/alu_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Command and response handshakes between a requester and the ALU sequencer.
interface alu_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_src_a;
   logic [2:0] cmd_src_b;
   logic [3:0] cmd_dst;
   logic       cmd_wb;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic       rsp_zero;
   logic       rsp_carry;
   logic       rsp_wb_dropped;

   modport master (
      output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_wb_dropped,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_zero, rsp_carry, rsp_wb_dropped,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: command FIFO feeding a read/exec/writeback/response FSM
// that drives a two-bank register file and an external ALU.
module alu_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_sequencer_if.slave bus,
   output logic [2:0] rd_slct_a,
   output logic [2:0] rd_slct_b,
   input  logic [7:0] data_a,
   input  logic [7:0] data_b,
   output logic [6:0] wrt_slct,
   output logic       wrtnbl,
   output logic [7:0] wr_data,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_op,
   input  logic [7:0] alu_c,
   input  logic       alu_zero,
   input  logic       alu_carry,
   output logic       busy
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] src_a;
      logic [2:0] src_b;
      logic [3:0] dst;
      logic       wb;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE, READ, EXEC, WB, RESP
   } state_t;

   state_t        state;
   state_t        state_nx;
   cmd_t          mem [FIFO_DEPTH];
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          hold;
   logic [2:0]    op_q;
   logic [3:0]    dst_q;
   logic          wb_q;
   logic          drop_q;
   logic [7:0]    res_q;
   logic          zero_q;
   logic          carry_q;

   assign full          = count == CW'(FIFO_DEPTH);
   assign empty         = count == '0;
   assign head          = mem[rd_ptr];
   assign bus.cmd_ready = rst_n & ~full;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign busy          = (state != IDLE) | ~empty;

   assign bus.rsp_data       = res_q;
   assign bus.rsp_zero       = zero_q;
   assign bus.rsp_carry      = carry_q;
   assign bus.rsp_wb_dropped = drop_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{op: bus.cmd_op, src_a: bus.cmd_src_a,
                             src_b: bus.cmd_src_b, dst: bus.cmd_dst,
                             wb: bus.cmd_wb};
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (!empty && !hold) state_nx = READ;
         READ: state_nx = EXEC;
         EXEC: state_nx = wb_q ? WB : RESP;
         WB:   state_nx = RESP;
         RESP: if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      pop           = 1'b0;
      wrtnbl        = 1'b0;
      bus.rsp_valid = 1'b0;
      unique case (1'b1)
         state == IDLE: pop = ~empty & ~hold;
         state == WB:   wrtnbl = ~drop_q;
         state == RESP: bus.rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // hold blocks the pop in the first IDLE cycle after a response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold      <= 1'b0;
         op_q      <= '0;
         dst_q     <= '0;
         wb_q      <= 1'b0;
         drop_q    <= 1'b0;
         rd_slct_a <= '0;
         rd_slct_b <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         res_q     <= '0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         wrt_slct  <= '0;
         wr_data   <= '0;
      end else begin
         hold <= (state == RESP) & bus.rsp_ready;
         if (pop) begin
            op_q      <= head.op;
            dst_q     <= head.dst;
            wb_q      <= head.wb;
            drop_q    <= head.wb & (head.dst[2:1] == 2'b00);
            rd_slct_a <= head.src_a;
            rd_slct_b <= head.src_b;
         end
         if (state == READ) begin
            alu_a  <= data_a;
            alu_b  <= data_b;
            alu_op <= op_q;
         end
         if (state == EXEC) begin
            res_q   <= alu_c;
            zero_q  <= alu_zero;
            carry_q <= alu_carry;
            if (wb_q && !drop_q) begin
               wrt_slct <= {3'b000, dst_q};
               wr_data  <= alu_c;
            end
         end
      end
   end
endmodule
